logit_streamer: RTL and testbench

- Transmit end of the class-score stream consumed by the argmax stage.
- Buffers NUM_CLASSES accumulator results written by the output dense layer, then scales them to 16-bit signed logits.
- On command, emits the logits in index order as a valid-qualified stream with a frame-enable (out_start) and an end-of-frame pulse.

---
 rtl/logit_streamer.sv | 137 +++++++++++++
 tb/tb_logit_streamer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/logit_streamer.sv
// Buffers NUM_CLASSES accumulator results as 16-bit logits and streams them out on request.
// Optional macro LOGIT_SAT_EN: saturate narrowed logits instead of wrapping.
module logit_streamer #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned SHIFT       = 8,
  parameter int unsigned GAP         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [ACC_W-1:0] wr_data,
  input  logic             send,
  output logic             busy,
  output logic [15:0]      out_data,
  output logic             out_valid,
  output logic             out_start,
  output logic             tx_done
);

  localparam int unsigned DW     = 16;
  localparam int unsigned BEAT_W = 4;
  localparam logic [BEAT_W-1:0] LAST   = BEAT_W'(NUM_CLASSES - 1);
  localparam logic [BEAT_W:0]   NC_EXT = (BEAT_W + 1)'(NUM_CLASSES);
  localparam logic [BEAT_W-1:0] GAP_LD = BEAT_W'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t            state, state_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [BEAT_W-1:0] gap_cnt, gap_n;
  logic              busy_n, valid_n, start_n, done_n;
  logic [DW-1:0]     data_n;

  logic signed [ACC_W-1:0] t;
  logic [DW-1:0]           conv;
  logic                    wr_ok;
  logic [DW-1:0]           mem [NUM_CLASSES];

  assign t = $signed(wr_data) >>> SHIFT;

`ifdef LOGIT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  always_comb begin
    if (t > SAT_HI)      conv = 16'h7FFF;
    else if (t < SAT_LO) conv = 16'h8000;
    else                 conv = DW'(t);
  end
`else
  assign conv = DW'(t);
`endif

  // Buffer is frozen while a frame is in flight; out-of-range indices are dropped.
  assign wr_ok = wr_en && !busy && (state == ST_IDLE) && ({1'b0, wr_addr} < NC_EXT);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= conv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat      <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      beat      <= beat_n;
      gap_cnt   <= gap_n;
      busy      <= busy_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_start <= start_n;
      tx_done   <= done_n;
    end
  end

  // Outputs lag the state by one edge, so beat k appears the cycle after SEND(k).
  always_comb begin
    state_n = state;
    beat_n  = beat;
    gap_n   = gap_cnt;
    busy_n  = busy;
    valid_n = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    data_n  = out_data;
    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (send && !busy) begin
          state_n = ST_SEND;
          beat_n  = '0;
          busy_n  = 1'b1;
        end
      end
      ST_SEND: begin
        busy_n  = 1'b1;
        valid_n = 1'b1;
        start_n = 1'b1;
        data_n  = mem[beat];
        if (beat == LAST) begin
          state_n = ST_DONE;
        end else if (GAP > 0) begin
          state_n = ST_GAP;
          gap_n   = GAP_LD;
        end else begin
          beat_n = beat + BEAT_W'(1);
        end
      end
      ST_GAP: begin
        busy_n  = 1'b1;
        start_n = 1'b1;
        if (gap_cnt == '0) begin
          state_n = ST_SEND;
          beat_n  = beat + BEAT_W'(1);
        end else begin
          gap_n = gap_cnt - BEAT_W'(1);
        end
      end
      ST_DONE: begin
        busy_n  = 1'b1;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_logit_streamer.sv
// Directed bench for logit_streamer: one instance with GAP=0, one with GAP=2.
module tb_logit_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en0, wr_en2;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        send0, send2;

  logic        b0, v0, st0, dn0;
  logic [15:0] d0;
  logic        b2, v2, st2, dn2;
  logic [15:0] d2;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [10];
  int          argmax;

  always #5 clk = ~clk;

  logit_streamer #(.NUM_CLASSES(10), .ACC_W(32), .SHIFT(8), .GAP(0)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send0), .busy(b0), .out_data(d0), .out_valid(v0), .out_start(st0), .tx_done(dn0)
  );

  logit_streamer #(.NUM_CLASSES(10), .ACC_W(32), .SHIFT(8), .GAP(2)) u_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send2), .busy(b2), .out_data(d2), .out_valid(v2), .out_start(st2), .tx_done(dn2)
  );

  function automatic logic [31:0] ctl0();
    return 32'({b0, v0, st0, dn0});
  endfunction

  function automatic logic [31:0] ctl2();
    return 32'({b2, v2, st2, dn2});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit both);
    wr_addr = 4'(a);
    wr_data = d;
    wr_en0  = 1'b1;
    wr_en2  = both;
    @(negedge clk);
    wr_en0  = 1'b0;
    wr_en2  = 1'b0;
  endtask

  // Runs one frame on u_dut; optionally pokes write+send at beat inject_k or resets after beat abort_k.
  task automatic frame0(input int inject_k, input int abort_k);
    logic signed [15:0] best;
    int best_i;
    best = '0;
    best_i = 0;
    send0 = 1'b1;
    @(negedge clk);
    send0 = 1'b0;
    wr_en0 = 1'b0;
    chk("accept_ctl", ctl0(), 32'h8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_en0 = 1'b0;
      send0 = 1'b0;
      chk($sformatf("beat%0d_ctl", k), ctl0(), 32'hE);
      chk($sformatf("beat%0d_data", k), 32'(d0), 32'(exp_q[k]));
      if (k == 0 || $signed(d0) > best) begin
        best = $signed(d0);
        best_i = k;
      end
      if (k == inject_k) begin
        wr_addr = 4'd5;
        wr_data = 32'h0055_5500;
        wr_en0 = 1'b1;
        send0 = 1'b1;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid", 32'({b0, v0, st0, dn0, d0}), 32'h0);
        return;
      end
    end
    @(negedge clk);
    chk("done_ctl", ctl0(), 32'h9);
    @(negedge clk);
    chk("idle_ctl", ctl0(), 32'h0);
    @(negedge clk);
    chk("idle2_ctl", ctl0(), 32'h0);
    argmax = best_i;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_en0 = 1'b0;
    wr_en2 = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    send0 = 1'b0;
    send2 = 1'b0;
    argmax = -1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_dut", 32'({b0, v0, st0, dn0, d0}), 32'h0);
    chk("reset_gap", 32'({b2, v2, st2, dn2, d2}), 32'h0);
    reset = 1'b0;

    // Basic frame: logits -300..600 in steps of 100.
    for (int k = 0; k < 10; k++) begin
      wr(k, 32'((k * 100 - 300) * 256), 1'b1);
      exp_q[k] = 16'(k * 100 - 300);
    end
    wr(12, 32'h0100_0000, 1'b1);
    frame0(-1, -1);
    chk("argmax_basic", 32'(argmax), 32'd9);

    // Gap pacing on the GAP=2 instance: beats every 3 cycles, 28 cycles of out_start.
    send2 = 1'b1;
    @(negedge clk);
    send2 = 1'b0;
    chk("gap_accept", ctl2(), 32'h8);
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      chk($sformatf("gap_c%0d_ctl", c), ctl2(), ((c - 1) % 3 == 0) ? 32'hE : 32'hA);
      chk($sformatf("gap_c%0d_data", c), 32'(d2), 32'(exp_q[(c - 1) / 3]));
    end
    @(negedge clk);
    chk("gap_done", ctl2(), 32'h9);
    @(negedge clk);
    chk("gap_idle", ctl2(), 32'h0);

    // Locked buffer: write to buf[5] and send during beat 2 are both ignored.
    frame0(2, -1);

    // Saturation / wrap of 0x7FFFFFFF >>> 8.
    wr(3, 32'h7FFF_FFFF, 1'b0);
`ifdef LOGIT_SAT_EN
    exp_q[3] = 16'h7FFF;
    frame0(-1, -1);
    chk("argmax_sat", 32'(argmax), 32'd3);
`else
    exp_q[3] = 16'hFFFF;
    frame0(-1, -1);
    chk("argmax_wrap", 32'(argmax), 32'd9);
`endif

    // Same-cycle write and send: frame carries the new buf[0].
    wr_addr = 4'd0;
    wr_data = 32'h0012_3400;
    wr_en0 = 1'b1;
    exp_q[0] = 16'h1234;
    frame0(-1, -1);

    // Reset after beat 4, then a full replay from index 0.
    frame0(-1, 4);
    chk("post_reset_gap", ctl2(), 32'h0);
    frame0(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
